// File: rtl/arb_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding and index-width helper.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    // Index width that stays at least 1 bit even for tiny requester counts.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping back to index 0.
module rr_pick
    import arb_pkg::*;
#(
    parameter int CORE_CNT = 256,
    parameter int IDX_WID  = idx_w(CORE_CNT)
) (
    input  logic [CORE_CNT-1:0] req,
    input  logic [IDX_WID-1:0]  ptr,
    output logic                found,
    output logic [IDX_WID-1:0]  idx
);

    logic [2*CORE_CNT-1:0] dbl;

    // Lower half keeps only requests at or above ptr; the upper half is the wrapped copy.
    // Scanning downward leaves the lowest set bit of the doubled vector as the winner.
    always_comb begin
        dbl   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < CORE_CNT; i++) begin
            dbl[i]            = req[i] && (i >= int'(ptr));
            dbl[i + CORE_CNT] = req[i];
        end
        for (int i = 2*CORE_CNT-1; i >= 0; i--) begin
            if (dbl[i]) begin
                found = 1'b1;
                idx   = IDX_WID'((i >= CORE_CNT) ? (i - CORE_CNT) : i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arb.sv
// Round-robin arbiter for the shared memory bus: one registered grant at a time, bounded hold
// length, and a single idle turnaround cycle after every grant.
module mem_bus_arb
    import arb_pkg::*;
#(
    parameter int  CORE_CNT = 256,
    parameter int  MAX_HOLD = 16,
    localparam int IDX_WID  = idx_w(CORE_CNT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CORE_CNT-1:0] req,
    output logic [CORE_CNT-1:0] grant,
    output logic [IDX_WID-1:0]  grant_idx,
    output logic                grant_vld,
    output logic                preempt
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    state_t               state, state_n;
    logic [HOLD_W-1:0]    hold_cnt, hold_cnt_n;
    logic [IDX_WID-1:0]   rr_ptr, rr_ptr_n;
    logic [CORE_CNT-1:0]  grant_n;
    logic [IDX_WID-1:0]   grant_idx_n;
    logic                 grant_vld_n;
    logic                 preempt_n;
    logic                 pick_found;
    logic [IDX_WID-1:0]   pick_idx;

    rr_pick #(
        .CORE_CNT (CORE_CNT),
        .IDX_WID  (IDX_WID)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            rr_ptr    <= '0;
            grant     <= '0;
            grant_idx <= '0;
            grant_vld <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_cnt_n;
            rr_ptr    <= rr_ptr_n;
            grant     <= grant_n;
            grant_idx <= grant_idx_n;
            grant_vld <= grant_vld_n;
            preempt   <= preempt_n;
        end
    end

    always_comb begin
        state_n     = state;
        hold_cnt_n  = hold_cnt;
        rr_ptr_n    = rr_ptr;
        grant_n     = grant;
        grant_idx_n = grant_idx;
        grant_vld_n = grant_vld;
        preempt_n   = 1'b0;

        unique case (state)
            ST_IDLE, ST_GAP: begin
                if (pick_found) begin
                    grant_n           = '0;
                    grant_n[pick_idx] = 1'b1;
                    grant_idx_n       = pick_idx;
                    grant_vld_n       = 1'b1;
                    hold_cnt_n        = HOLD_W'(1);
                    rr_ptr_n          = (pick_idx == IDX_WID'(CORE_CNT - 1)) ? '0
                                                                              : pick_idx + IDX_WID'(1);
                    state_n           = ST_GRANT;
                end else begin
                    grant_n     = '0;
                    grant_vld_n = 1'b0;
                    state_n     = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // Release wins over the hold limit when both happen on the same edge.
                if (!req[grant_idx]) begin
                    grant_n     = '0;
                    grant_vld_n = 1'b0;
                    hold_cnt_n  = '0;
                    state_n     = ST_GAP;
                end else if (hold_cnt == HOLD_W'(MAX_HOLD)) begin
                    grant_n     = '0;
                    grant_vld_n = 1'b0;
                    hold_cnt_n  = '0;
                    preempt_n   = 1'b1;
                    state_n     = ST_GAP;
                end else begin
                    hold_cnt_n  = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                grant_n     = '0;
                grant_vld_n = 1'b0;
                hold_cnt_n  = '0;
                state_n     = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arb.sv
// Bench for mem_bus_arb (8 cores, hold limit 4): directed scenarios plus randomized requests
// checked every cycle against a queue-free ownership model.
module tb_mem_bus_arb;

    localparam int N  = 8;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = 8'hFF;
    logic [N-1:0] grant;
    logic [2:0]   grant_idx;
    logic         grant_vld;
    logic         preempt;

    always #5 clk = ~clk;

    mem_bus_arb #(.CORE_CNT(N), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .preempt   (preempt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus, how long they have held it, where the next search starts.
    int           m_owner = -1;
    int           m_held  = 0;
    int           m_ptr   = 0;
    int           m_last  = 0;
    bit           m_pre   = 1'b0;
    bit           m_found;
    logic [N-1:0] eg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_last = 0; m_pre = 1'b0;
        end else begin
            m_pre = 1'b0;
            if (m_owner >= 0) begin
                if (!req[m_owner]) m_owner = -1;
                else if (m_held == MH) begin m_owner = -1; m_pre = 1'b1; end
                else m_held++;
            end else begin
                m_found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!m_found && req[(m_ptr + k) % N]) begin
                        m_found = 1'b1;
                        m_owner = (m_ptr + k) % N;
                    end
                end
                if (m_found) begin
                    m_held = 1; m_last = m_owner; m_ptr = (m_owner + 1) % N;
                end
            end
        end
    end

    always @(negedge clk) begin
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("grant", grant, eg);
        chk("grant_idx", grant_idx, m_last);
        chk("grant_vld", grant_vld, (m_owner >= 0));
        chk("preempt", preempt, m_pre);
        chk("onehot", $onehot0(grant), 1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [N-1:0] g3 [6]  = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h04};
    bit           p3 [6]  = '{0, 0, 0, 0, 1, 0};
    logic [N-1:0] g4 [11] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00,
                              8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h04};
    bit           p4 [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    int           rot_exp [4] = '{0, 3, 5, 0};

    initial begin
        int           seq [$];
        int           cnt [N];
        logic [N-1:0] drop;
        bit           prev_vld;
        int           hold;
        logic [N-1:0] pat;

        // Reset held with every core requesting, then one edge to the first grant.
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_vld", grant_vld, 0);
        chk("rst_preempt", preempt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant", grant, 8'h01);

        // Rotation: each core drops its request after two granted cycles.
        do_reset();
        drop = '0; prev_vld = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int cyc = 0; cyc < 40 && seq.size() < 4; cyc++) begin
            req = 8'h29 & ~drop;
            @(negedge clk);
            if (grant_vld) begin
                if (!prev_vld) seq.push_back(int'(grant_idx));
                cnt[grant_idx]++;
                if (cnt[grant_idx] == 2) drop[grant_idx] = 1'b1;
            end else begin
                drop = '0;
                for (int i = 0; i < N; i++) cnt[i] = 0;
            end
            prev_vld = grant_vld;
        end
        chk("rot_count", seq.size(), 4);
        for (int i = 0; i < 4; i++) chk("rot_order", (i < seq.size()) ? seq[i] : -1, rot_exp[i]);

        // Sole requester hits the hold limit and is re-granted after the gap.
        do_reset();
        req = 8'h04;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("pre_grant", grant, g3[i]);
            chk("pre_pulse", preempt, p3[i]);
        end

        // Two requesters alternate on hold-limit preemption.
        do_reset();
        req = 8'h84;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("fair_grant", grant, g4[i]);
            chk("fair_pulse", preempt, p4[i]);
        end

        // Pointer wraps from core 7 back to core 0.
        do_reset();
        req = 8'h80;
        @(negedge clk);
        chk("wrap_g7", grant, 8'h80);
        req = 8'h00;
        @(negedge clk);
        chk("wrap_gap", grant, 8'h00);
        req = 8'h81;
        @(negedge clk);
        chk("wrap_g0", grant, 8'h01);

        // Asynchronous reset between edges clears the grant at once.
        do_reset();
        req = 8'h10;
        @(negedge clk);
        chk("arst_pre", grant, 8'h10);
        req = 8'h38;
        #1 rst = 1'b1;
        #1 chk("arst_clear", grant, 8'h00);
        chk("arst_vld", grant_vld, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("arst_next", grant, 8'h08);

        // Randomized request patterns held for random stretches, with rare mid-cycle resets.
        do_reset();
        hold = 0;
        pat = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 8);
                case ($urandom_range(0, 3))
                    0: pat = N'($urandom);
                    1: pat = N'(1) << $urandom_range(0, N-1);
                    2: pat = '0;
                    default: pat = (N'(1) << $urandom_range(0, N-1)) | (N'(1) << $urandom_range(0, N-1));
                endcase
            end
            req = pat;
            hold--;
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            @(negedge clk);
        end

        req = '0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
